// File: rtl/md_unit.sv
// md_unit: 32-bit MIPS-style multiply/divide unit with architectural HI/LO registers.
// Define MD_FAST_MUL_EN for single-cycle MULT/MULTU; DIV/DIVU always use the 33-cycle path.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_busy;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic [W-1:0]  r_opb;
  logic [W-1:0]  r_a_raw;
  logic          r_is_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_b_zero;

  logic          w_launch;
  logic          w_step;
  logic          w_fix;
  logic          w_mt_en;

  // Operand magnitudes taken at launch; unsigned ops never negate.
  logic          w_neg_a;
  logic          w_neg_b;
  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;

  assign w_neg_a = ~op[0] & rs_data[W-1];
  assign w_neg_b = ~op[0] & rt_data[W-1];
  assign w_abs_a = w_neg_a ? W'(-rs_data) : rs_data;
  assign w_abs_b = w_neg_b ? W'(-rt_data) : rt_data;

  // Shift-add step: acc holds {partial product, remaining multiplier}.
  logic [W:0]    w_mul_sum;
  logic [DW-1:0] w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[DW-1:W]} + {1'b0, r_opb};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]}
                              : {1'b0, r_acc[DW-1:1]};

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  logic [W:0]    w_div_rem;
  logic [W:0]    w_div_diff;
  logic [DW-1:0] w_div_nxt;

  assign w_div_rem  = {r_acc[DW-1:W], r_acc[W-1]};
  assign w_div_diff = w_div_rem - {1'b0, r_opb};
  assign w_div_nxt  = w_div_diff[W] ? {w_div_rem[W-1:0], r_acc[W-2:0], 1'b0}
                                    : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

  // Sign correction applied in FIX.
  logic [DW-1:0] w_prod;
  logic [W-1:0]  w_quot;
  logic [W-1:0]  w_rem;

  assign w_prod = r_neg_q ? DW'(-r_acc) : r_acc;
  assign w_quot = r_neg_q ? W'(-r_acc[W-1:0]) : r_acc[W-1:0];
  assign w_rem  = r_neg_r ? W'(-r_acc[DW-1:W]) : r_acc[DW-1:W];

`ifdef MD_FAST_MUL_EN
  logic          w_fast_mul;
  logic [DW-1:0] w_fast_a;
  logic [DW-1:0] w_fast_b;
  logic [DW-1:0] w_fast_prod;

  // Low 64 bits of the extended product are exact for both signed and unsigned.
  assign w_fast_a    = {{W{w_neg_a}}, rs_data};
  assign w_fast_b    = {{W{w_neg_b}}, rt_data};
  assign w_fast_prod = DW'(w_fast_a * w_fast_b);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    w_mt_en     = 1'b0;
`ifdef MD_FAST_MUL_EN
    w_fast_mul  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef MD_FAST_MUL_EN
          if (!op[1]) begin
            w_fast_mul = 1'b1;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = RUN;
          end
`else
          w_launch    = 1'b1;
          w_state_nxt = RUN;
`endif
        end else begin
          w_mt_en = 1'b1;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(W - 1)) w_state_nxt = FIX;
      end
      FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      if (w_launch) begin
        r_cnt    <= '0;
        r_acc    <= {{W{1'b0}}, w_abs_a};
        r_opb    <= w_abs_b;
        r_a_raw  <= rs_data;
        r_is_div <= op[1];
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
        r_b_zero <= (rt_data == '0);
      end else if (w_step) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end

      if (w_fix) begin
        if (!r_is_div) begin
          r_hi <= w_prod[DW-1:W];
          r_lo <= w_prod[W-1:0];
        end else if (r_b_zero) begin
          r_hi <= r_a_raw;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
`ifdef MD_FAST_MUL_EN
      end else if (w_fast_mul) begin
        r_hi <= w_fast_prod[DW-1:W];
        r_lo <= w_fast_prod[W-1:0];
`endif
      end else if (w_mt_en) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against a behavioural HI/LO model.
// Expected results are queued at launch and compared when busy falls.
module tb_md_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

`ifdef MD_FAST_MUL_EN
  localparam bit         FAST     = 1'b1;
  localparam logic [1:0] ABORT_OP = DIVU;
`else
  localparam bit         FAST     = 1'b0;
  localparam logic [1:0] ABORT_OP = MULT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} using wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic        [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      MULT: begin
        p = sa * sb;
        return p;
      end
      MULTU: return {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // mode: 0 plain, 1 start+MTHI pulse mid-run, 2 reset at busy cycle 10, 3 MTHI/MTLO with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    int          n;
    int          exp_len;
    logic [63:0] e;
    exp_len = (FAST && !o[1]) ? 0 : 33;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    if (mode == 3) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (mode == 1 && n == 5) begin
        start   = 1'b1;
        op      = MULTU;
        rs_data = 32'd2;
        rt_data = 32'd2;
        hi_we   = 1'b1;
        wdata   = 32'd5;
      end
      if (mode == 1 && n == 6) begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      if (n == 20) begin
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
      end
      if (mode == 2 && n == 10) begin
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        void'(sb_q.pop_front());
        m_hi = '0;
        m_lo = '0;
        return;
      end
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'(exp_len));
    e    = sb_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;

    #12;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // MTHI + MTLO together, then MTLO alone
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    m_hi  = 32'hA5A5_A5A5;
    m_lo  = 32'hA5A5_A5A5;
    check("mt_both_hi", hi, m_hi);
    check("mt_both_lo", lo, m_lo);
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    m_lo  = 32'h0000_1234;
    check("mtlo_hi", hi, m_hi);
    check("mtlo_lo", lo, m_lo);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(MULT, 32'hFFFF_FFF9, 32'd3, 0);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(DIVU, 32'd100, 32'd0, 0);
    check("divz_hi", hi, 32'd100);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    run_op(DIV, 32'hFFFF_FFF8, 32'd0, 0);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(DIVU, 32'd100, 32'd7, 1);
    check("ignore_lo", lo, 32'd14);
    check("ignore_hi", hi, 32'd2);
    run_op(DIVU, 32'd45, 32'd9, 3);
    run_op(ABORT_OP, 32'd12345, 32'd678, 2);
    @(negedge clk);
    rst = 1'b1;
    run_op(MULTU, 32'd3, 32'd4, 0);
    check("post_rst_lo", lo, 32'd12);
    run_op(MULTU, 32'd6, 32'd7, 0);
    run_op(DIVU, 32'd42, 32'd6, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, (i == 2) ? 32'h0 : $urandom, 0);
    end
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (asserted when 0).
REQ-003 SHALL have port start, input, 1 bit: launch the operation selected by op when the unit is idle.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port rs_data, input, 32 bits: operand A (multiplicand or dividend), taken from register-file read port 1.
REQ-006 SHALL have port rt_data, input, 32 bits: operand B (multiplier or divisor), taken from register-file read port 2.
REQ-007 SHALL have port hi_we, input, 1 bit: MTHI, writes wdata into HI.
REQ-008 SHALL have port lo_we, input, 1 bit: MTLO, writes wdata into LO.
REQ-009 SHALL have port wdata, input, 32 bits: data for MTHI/MTLO.
REQ-010 SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV while it is high.
REQ-011 SHALL have port hi, output, 32 bits: HI register; MFHI source to the register-file write data.
REQ-012 SHALL have port lo, output, 32 bits: LO register; MFLO source.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 In IDLE, start=1 SHALL latch rs_data, rt_data and op, clear the step counter and go to RUN at that edge.
REQ-015 RUN SHALL last exactly 32 cycles, performing one step per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-016 For the signed ops (MULT, DIV), the unit SHALL take absolute values at launch and apply the sign correction in FIX.
- Product sign = sign(A) XOR sign(B).
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
REQ-017 FIX SHALL last 1 cycle, then write HI/LO and return to IDLE on the same edge.
- Total: busy high for 33 cycles after the start edge.
- HI/LO are valid in the first cycle busy reads 0.
REQ-018 Multiply results: HI = product[63:32], LO = product[31:0].
REQ-019 Divide results: LO = quotient, HI = remainder.
REQ-020 Divide by zero (rt_data=0) SHALL give LO=32'hFFFF_FFFF and HI=rs_data, with no trap and the same latency.
REQ-021 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000, HI=0.
REQ-022 start while busy SHALL be ignored; operands and op are not re-latched.
REQ-023 hi_we/lo_we while busy SHALL be ignored.
REQ-024 hi_we/lo_we in IDLE SHALL update HI/LO at that edge.
- Both asserted: both are written.
- start in the same cycle wins, and the writes are discarded.
REQ-025 HI/LO SHALL hold their values between operations and during RUN/FIX; no partial results are visible.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, busy=0, hi=0, lo=0, and clear all internal operand, accumulator and counter registers.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no HI/LO update; after release the unit accepts start on the first clock edge.

Configuration
REQ-028 The macro MD_FAST_MUL_EN SHALL select fast multiply.
- Defined: MULT/MULTU compute a single-cycle 32x32 product and write HI/LO at the start edge itself. busy stays 0 and the state stays IDLE. DIV/DIVU are unchanged.
- Undefined: all four ops use the 33-cycle iterative path.

Verification
REQ-029 MULTU rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF -> after 33 busy cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-030 MULT rs=-7 (32'hFFFF_FFF9), rt=3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB. DIV rs=-7, rt=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
REQ-031 DIVU rs=100, rt=0 -> LO=32'hFFFF_FFFF, HI=100, busy 33 cycles.
REQ-032 Launch DIVU 100/7; at busy cycle 5, pulse start (MULTU 2*2) and hi_we (wdata=5) -> both ignored; final LO=14, HI=2.
REQ-033 Launch MULT, assert rst=0 at busy cycle 10 -> busy, hi and lo drop to 0 immediately; after release, start MULTU 3*4 -> LO=12, HI=0.
REQ-034 With MD_FAST_MUL_EN defined: MULTU 6*7 -> LO=42, HI=0 at the next edge, busy never 1. DIVU 42/6 -> LO=7, HI=0 after 33 busy cycles.
